// File: rtl/frv_irq_pkg.sv
// frv interrupt controller: shared cause codes, MMIO map, FSM states.
// Imported by the controller top and its arbiter.
package frv_irq_pkg;

  localparam int ID_W    = 5;
  localparam int CAUSE_W = 6;

  localparam logic [CAUSE_W-1:0] CAUSE_NMI   = 6'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_SW    = 6'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMER = 6'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_EXT   = 6'd16;

  localparam logic [31:0] OFF_PENDING = 32'h00;
  localparam logic [31:0] OFF_ENABLE  = 32'h04;
  localparam logic [31:0] OFF_MODE    = 32'h08;
  localparam logic [31:0] OFF_THRESH  = 32'h0C;
  localparam logic [31:0] OFF_CLAIMED = 32'h10;
  localparam logic [31:0] OFF_PRIO    = 32'h40;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

  function automatic logic [CAUSE_W-1:0] ext_cause(
    input logic [ID_W-1:0] id
  );
    return CAUSE_EXT + {1'b0, id};
  endfunction

endpackage

// File: rtl/frv_irq_arb.sv
// frv interrupt controller: priority arbiter over eligible sources.
// Highest prio above threshold wins; ties resolve to the lowest index.
module frv_irq_arb
  import frv_irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic [NUM_SRC-1:0]             i_req,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] i_prio,
  input  logic [PRIO_W-1:0]              i_thresh,
  output logic                           o_any,
  output logic [ID_W-1:0]                o_id
);

  logic [PRIO_W-1:0] w_best;

  // Strict compare keeps the earlier (lower) index on equal prio.
  always_comb begin
    w_best = i_thresh;
    o_any  = 1'b0;
    o_id   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_req[i] && (i_prio[i] > w_best)) begin
        w_best = i_prio[i];
        o_any  = 1'b1;
        o_id   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/frv_irq_ctrl.sv
// frv interrupt controller: source capture, MMIO registers and the
// trap request FSM towards the writeback stage.
module frv_irq_ctrl
  import frv_irq_pkg::*;
#(
  parameter int          NUM_SRC        = 8,
  parameter int          PRIO_W         = 3,
  parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_2000,
  parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic [NUM_SRC-1:0]   src_irq,
  input  logic                 nmi_pending,
  input  logic                 ti_pending,
  input  logic                 sw_pending,
  input  logic                 mstatus_mie,
  input  logic [2:0]           mie_en,
  output logic [2:0]           mip_out,
  output logic                 int_trap_req,
  output logic [CAUSE_W-1:0]   int_trap_cause,
  input  logic                 int_trap_ack,
  input  logic                 mmio_en,
  input  logic                 mmio_wen,
  input  logic [31:0]          mmio_addr,
  input  logic [31:0]          mmio_wdata,
  output logic [31:0]          mmio_rdata,
  output logic                 mmio_error
);

  logic [NUM_SRC-1:0]             r_src_q;
  logic [NUM_SRC-1:0]             r_src_d;
  logic [NUM_SRC-1:0]             r_pending;
  logic [NUM_SRC-1:0]             r_enable;
  logic [NUM_SRC-1:0]             r_mode;
  logic [NUM_SRC-1:0][PRIO_W-1:0] r_prio;
  logic [PRIO_W-1:0]              r_thresh;
  logic [ID_W-1:0]                r_claimed;
  logic [ID_W-1:0]                r_ext_id;
  logic [ID_W-1:0]                r_req_id;
  logic                           r_req_ext;
  logic [2:0]                     r_mip;
  irq_state_e                     r_state;
  logic                           r_req;
  logic [CAUSE_W-1:0]             r_cause;
  logic [31:0]                    r_rdata;
  logic                           r_err;

  logic                           w_hit;
  logic [31:0]                    w_off;
  logic                           w_map;
  logic [31:0]                    w_rd;
  logic                           w_bad;
  logic                           w_wr;
  logic                           w_claim;
  logic [NUM_SRC-1:0]             w_set;
  logic [NUM_SRC-1:0]             w_clr;
  logic                           w_any;
  logic [ID_W-1:0]                w_id;
  logic                           w_q_ext;
  logic                           w_q_sw;
  logic                           w_q_tm;
  logic                           w_unused_ok;

  assign w_unused_ok = &{1'b0, mmio_wdata};

  assign w_hit = ((mmio_addr ^ MMIO_BASE_ADDR)
                  & MMIO_BASE_MASK) == '0;
  assign w_off = mmio_addr & ~MMIO_BASE_MASK;

  always_comb begin
    w_map = 1'b1;
    w_rd  = '0;
    case (w_off)
      OFF_PENDING: w_rd = 32'(r_pending);
      OFF_ENABLE:  w_rd = 32'(r_enable);
      OFF_MODE:    w_rd = 32'(r_mode);
      OFF_THRESH:  w_rd = 32'(r_thresh);
      OFF_CLAIMED: w_rd = 32'(r_claimed);
      default: begin
        w_map = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (w_off == OFF_PRIO + 32'(4 * i)) begin
            w_map = 1'b1;
            w_rd  = 32'(r_prio[i]);
          end
        end
      end
    endcase
  end

  assign w_bad = !w_hit || !w_map ||
                 (mmio_wen && (w_off == OFF_CLAIMED));
  assign w_wr  = mmio_en && mmio_wen && !w_bad;

  assign w_claim = (r_state == ST_REQ) && int_trap_ack &&
                   r_req_ext;

  // Edge mode looks at the registered line against its last value.
  assign w_set = (r_mode & r_src_q & ~r_src_d) |
                 (~r_mode & r_src_q);

  always_comb begin
    w_clr = '0;
    if (w_wr && (w_off == OFF_PENDING))
      w_clr = mmio_wdata[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_claim && (r_req_id == ID_W'(i)))
        w_clr[i] = 1'b1;
    end
  end

  frv_irq_arb #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W)
  ) u_arb (
    .i_req    (r_pending & r_enable),
    .i_prio   (r_prio),
    .i_thresh (r_thresh),
    .o_any    (w_any),
    .o_id     (w_id)
  );

  assign w_q_ext = mstatus_mie && mie_en[2] && r_mip[2];
  assign w_q_sw  = mstatus_mie && mie_en[0] && r_mip[0];
  assign w_q_tm  = mstatus_mie && mie_en[1] && r_mip[1];

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_src_q   <= '0;
      r_src_d   <= '0;
      r_pending <= '0;
      r_enable  <= '0;
      r_mode    <= '0;
      r_prio    <= '0;
      r_thresh  <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_src_q   <= src_irq;
      r_src_d   <= r_src_q;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_rdata   <= (mmio_en && !w_bad) ? w_rd : '0;
      r_err     <= mmio_en && w_bad;
      if (w_wr) begin
        case (w_off)
          OFF_ENABLE: r_enable <= mmio_wdata[NUM_SRC-1:0];
          OFF_MODE:   r_mode   <= mmio_wdata[NUM_SRC-1:0];
          OFF_THRESH: r_thresh <= mmio_wdata[PRIO_W-1:0];
          default: begin
            for (int i = 0; i < NUM_SRC; i++) begin
              if (w_off == OFF_PRIO + 32'(4 * i))
                r_prio[i] <= mmio_wdata[PRIO_W-1:0];
            end
          end
        endcase
      end
    end
  end

  // A claim hides the stale arbiter result for one cycle so the
  // just-claimed id cannot be re-requested.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_mip    <= '0;
      r_ext_id <= '0;
    end else begin
      r_mip    <= {w_any && !w_claim, ti_pending, sw_pending};
      r_ext_id <= w_id;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_cause   <= '0;
      r_req_ext <= 1'b0;
      r_req_id  <= '0;
      r_claimed <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (nmi_pending) begin
            r_state   <= ST_REQ;
            r_req     <= 1'b1;
            r_cause   <= CAUSE_NMI;
            r_req_ext <= 1'b0;
          end else if (w_q_ext) begin
            r_state   <= ST_REQ;
            r_req     <= 1'b1;
            r_cause   <= ext_cause(r_ext_id);
            r_req_ext <= 1'b1;
            r_req_id  <= r_ext_id;
          end else if (w_q_sw) begin
            r_state   <= ST_REQ;
            r_req     <= 1'b1;
            r_cause   <= CAUSE_SW;
            r_req_ext <= 1'b0;
          end else if (w_q_tm) begin
            r_state   <= ST_REQ;
            r_req     <= 1'b1;
            r_cause   <= CAUSE_TIMER;
            r_req_ext <= 1'b0;
          end
        end
        ST_REQ: begin
          if (int_trap_ack) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_req_ext <= 1'b0;
            if (r_req_ext)
              r_claimed <= r_req_id;
          end else if (nmi_pending) begin
            r_cause   <= CAUSE_NMI;
            r_req_ext <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mip_out        = r_mip;
  assign int_trap_req   = r_req;
  assign int_trap_cause = r_cause;
  assign mmio_rdata     = r_rdata;
  assign mmio_error     = r_err;

endmodule

// File: tb/tb_frv_irq_ctrl.sv
// Self-checking bench for frv_irq_ctrl: MMIO vector table, directed
// trap sequences and randomized arbitration against a reference model.
module tb_frv_irq_ctrl;

  localparam logic [31:0] B = 32'h0000_2000;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic [7:0]  src_irq;
  logic        nmi_pending, ti_pending, sw_pending;
  logic        mstatus_mie;
  logic [2:0]  mie_en;
  logic [2:0]  mip_out;
  logic        int_trap_req;
  logic [5:0]  int_trap_cause;
  logic        int_trap_ack;
  logic        mmio_en, mmio_wen;
  logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
  logic        mmio_error;

  int total = 0;
  int bad   = 0;

  always #5 g_clk = ~g_clk;

  frv_irq_ctrl dut (
    .g_clk          (g_clk),
    .g_resetn       (g_resetn),
    .src_irq        (src_irq),
    .nmi_pending    (nmi_pending),
    .ti_pending     (ti_pending),
    .sw_pending     (sw_pending),
    .mstatus_mie    (mstatus_mie),
    .mie_en         (mie_en),
    .mip_out        (mip_out),
    .int_trap_req   (int_trap_req),
    .int_trap_cause (int_trap_cause),
    .int_trap_ack   (int_trap_ack),
    .mmio_en        (mmio_en),
    .mmio_wen       (mmio_wen),
    .mmio_addr      (mmio_addr),
    .mmio_wdata     (mmio_wdata),
    .mmio_rdata     (mmio_rdata),
    .mmio_error     (mmio_error)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl[18];

  logic [7:0] m_en;
  int         m_thr;
  int         m_prio[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mmio(input logic [31:0] a, input logic w,
                      input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    @(negedge g_clk);
    mmio_en = 1'b1; mmio_wen = w;
    mmio_addr = a; mmio_wdata = d;
    @(posedge g_clk); #1;
    mmio_en = 1'b0; mmio_wen = 1'b0;
    rd = mmio_rdata; er = mmio_error;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] rd; logic er;
    mmio(B + off, 1'b1, d, rd, er);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] off,
                        input logic [31:0] exp);
    logic [31:0] rd; logic er;
    mmio(B + off, 1'b0, 32'h0, rd, er);
    chk(nm, rd, exp);
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge g_clk); src_irq = m;
    @(negedge g_clk); src_irq = 8'h00;
    repeat (3) @(negedge g_clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge g_clk); #1;
      if (int_trap_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_trap();
    @(negedge g_clk);
    int_trap_ack = 1'b1; mie_en = 3'b000;
    @(posedge g_clk); #1;
    int_trap_ack = 1'b0;
    chk("req_after_ack", 32'(int_trap_req), 32'h0);
  endtask

  task automatic take(input logic [5:0] exp, input string nm);
    bit ok;
    wait_req(ok);
    chk({nm, "_req"}, 32'(ok), 32'h1);
    chk({nm, "_cause"}, 32'(int_trap_cause), 32'(exp));
    ack_trap();
  endtask

  // Reference: find the top priority first, then the first source
  // holding it; nothing wins unless that priority beats threshold.
  function automatic int ref_winner(input logic [7:0] act);
    int maxp = -1;
    for (int i = 0; i < 8; i++)
      if (act[i] && m_prio[i] > maxp) maxp = m_prio[i];
    if (maxp <= m_thr) return -1;
    for (int i = 0; i < 8; i++)
      if (act[i] && m_prio[i] == maxp) return i;
    return -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    bit          ok;
    int          w;

    tbl[0]  = '{B + 32'h004, 1, 32'hFFFF_FFFF, 0, 32'h0,  0};
    tbl[1]  = '{B + 32'h004, 0, 32'h0,         1, 32'hFF, 0};
    tbl[2]  = '{B + 32'h008, 1, 32'h0000_0155, 0, 32'h0,  0};
    tbl[3]  = '{B + 32'h008, 0, 32'h0,         1, 32'h55, 0};
    tbl[4]  = '{B + 32'h00C, 1, 32'h0000_000F, 0, 32'h0,  0};
    tbl[5]  = '{B + 32'h00C, 0, 32'h0,         1, 32'h7,  0};
    tbl[6]  = '{B + 32'h05C, 1, 32'hFFFF_FFFF, 0, 32'h0,  0};
    tbl[7]  = '{B + 32'h05C, 0, 32'h0,         1, 32'h7,  0};
    tbl[8]  = '{B + 32'h060, 0, 32'h0,         0, 32'h0,  1};
    tbl[9]  = '{B + 32'h7FC, 0, 32'h0,         0, 32'h0,  1};
    tbl[10] = '{B + 32'h010, 1, 32'h0000_001F, 0, 32'h0,  1};
    tbl[11] = '{B + 32'h010, 0, 32'h0,         1, 32'h0,  0};
    tbl[12] = '{32'h3004,    1, 32'h0,         0, 32'h0,  1};
    tbl[13] = '{B + 32'h004, 0, 32'h0,         1, 32'hFF, 0};
    tbl[14] = '{B + 32'h041, 0, 32'h0,         0, 32'h0,  1};
    tbl[15] = '{B + 32'h000, 1, 32'h0000_00FF, 0, 32'h0,  0};
    tbl[16] = '{B + 32'h000, 0, 32'h0,         1, 32'h0,  0};
    tbl[17] = '{B + 32'h014, 0, 32'h0,         0, 32'h0,  1};

    g_resetn = 1'b0; src_irq = '0;
    nmi_pending = 0; ti_pending = 0; sw_pending = 0;
    mstatus_mie = 1'b1; mie_en = 3'b000; int_trap_ack = 0;
    mmio_en = 0; mmio_wen = 0; mmio_addr = '0; mmio_wdata = '0;
    repeat (3) @(posedge g_clk);
    #1;
    chk("rst_req", 32'(int_trap_req), 32'h0);
    chk("rst_cause", 32'(int_trap_cause), 32'h0);
    chk("rst_mip", 32'(mip_out), 32'h0);
    chk("rst_rdata", mmio_rdata, 32'h0);
    chk("rst_err", 32'(mmio_error), 32'h0);
    @(negedge g_clk); g_resetn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      mmio(tbl[i].addr, tbl[i].wen, tbl[i].wdata, rd, er);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].err));
      if (tbl[i].chk_rd)
        chk($sformatf("vec%0d_rd", i), rd, tbl[i].rdata);
    end
    wr(32'h04, 0); wr(32'h08, 0); wr(32'h0C, 0); wr(32'h5C, 0);

    // External edge source, claim on ack.
    wr(32'h04, 32'h04); wr(32'h08, 32'h04); wr(32'h48, 3);
    mie_en = 3'b100;
    pulse(8'h04);
    wait_req(ok);
    chk("e2_req", 32'(ok), 32'h1);
    chk("e2_cause", 32'(int_trap_cause), 32'd18);
    chk("e2_mip", 32'(mip_out[2]), 32'h1);
    rd_chk("e2_pend_before", 32'h00, 32'h04);
    ack_trap();
    rd_chk("e2_pend_after", 32'h00, 32'h00);
    rd_chk("e2_claimed", 32'h10, 32'h02);

    // Tie at prio 4 goes to src 1; then src 5 at prio 6 wins.
    wr(32'h04, 32'h22); wr(32'h08, 32'h22);
    wr(32'h44, 4); wr(32'h54, 4);
    pulse(8'h22);
    mie_en = 3'b100;
    take(6'd17, "tie");
    wr(32'h00, 32'hFF);
    wr(32'h54, 6);
    pulse(8'h22);
    mie_en = 3'b100;
    take(6'd21, "hi5");
    wr(32'h00, 32'hFF);
    rd_chk("hi5_claimed", 32'h10, 32'h05);

    // Threshold gating.
    wr(32'h04, 32'h08); wr(32'h08, 32'h08);
    wr(32'h4C, 4); wr(32'h0C, 4);
    mie_en = 3'b100;
    pulse(8'h08);
    repeat (8) @(posedge g_clk);
    #1;
    chk("thr_noreq", 32'(int_trap_req), 32'h0);
    wr(32'h4C, 5);
    take(6'd19, "thr5");
    wr(32'h0C, 0); wr(32'h00, 32'hFF);

    // Software beats timer; NMI retargets the latched cause.
    wr(32'h04, 0);
    mie_en = 3'b011; ti_pending = 1; sw_pending = 1;
    wait_req(ok);
    chk("sw_req", 32'(ok), 32'h1);
    chk("sw_cause", 32'(int_trap_cause), 32'd3);
    @(negedge g_clk); nmi_pending = 1;
    repeat (2) @(posedge g_clk);
    #1;
    chk("nmi_req", 32'(int_trap_req), 32'h1);
    chk("nmi_cause", 32'(int_trap_cause), 32'd0);
    ack_trap();
    nmi_pending = 0; ti_pending = 0; sw_pending = 0;
    repeat (3) @(negedge g_clk);

    // Randomized level-mode arbitration.
    wr(32'h08, 0);
    for (int it = 0; it < 40; it++) begin
      int exp;
      int k;
      logic [7:0] s;
      mie_en = 3'b000;
      w = int'($urandom);
      m_en = w[7:0];
      m_thr = int'($urandom_range(0, 7));
      wr(32'h04, 32'(w));
      wr(32'h0C, 32'(m_thr));
      for (int i = 0; i < 8; i++) begin
        m_prio[i] = int'($urandom_range(0, 7));
        wr(32'h40 + 32'(4 * i), 32'(m_prio[i]));
      end
      rd_chk("rnd_en", 32'h04, 32'(m_en));
      rd_chk("rnd_thr", 32'h0C, 32'(m_thr));
      k = int'($urandom_range(0, 7));
      rd_chk("rnd_prio", 32'h40 + 32'(4 * k), 32'(m_prio[k]));
      s = 8'($urandom);
      @(negedge g_clk); src_irq = s;
      repeat (3) @(negedge g_clk);
      exp = ref_winner(s & m_en);
      mie_en = 3'b100;
      if (exp >= 0) begin
        take(6'(16 + exp), "rnd");
      end else begin
        repeat (6) @(posedge g_clk);
        #1;
        chk("rnd_noreq", 32'(int_trap_req), 32'h0);
        chk("rnd_nomip", 32'(mip_out[2]), 32'h0);
        mie_en = 3'b000;
      end
      src_irq = 8'h00;
      repeat (2) @(negedge g_clk);
      wr(32'h00, 32'hFF);
      repeat (2) @(negedge g_clk);
    end

    // Asynchronous reset while a trap is requested.
    wr(32'h04, 32'hAA); wr(32'h08, 32'h0F);
    wr(32'h0C, 2); wr(32'h50, 6);
    @(negedge g_clk); src_irq = 8'h80;
    repeat (3) @(negedge g_clk);
    mie_en = 3'b001; sw_pending = 1;
    wait_req(ok);
    chk("rst2_req_before", 32'(ok), 32'h1);
    #2 g_resetn = 1'b0;
    #1;
    chk("rst2_req", 32'(int_trap_req), 32'h0);
    chk("rst2_cause", 32'(int_trap_cause), 32'h0);
    chk("rst2_mip", 32'(mip_out), 32'h0);
    sw_pending = 0; mie_en = 3'b000; src_irq = 8'h00;
    @(negedge g_clk); g_resetn = 1'b1;
    rd_chk("rst2_pend", 32'h00, 32'h0);
    rd_chk("rst2_en", 32'h04, 32'h0);
    rd_chk("rst2_mode", 32'h08, 32'h0);
    rd_chk("rst2_thr", 32'h0C, 32'h0);
    rd_chk("rst2_claimed", 32'h10, 32'h0);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("rst2_prio%0d", i),
             32'h40 + 32'(4 * i), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
